// File: rtl/register_stack.sv
// register_stack: LIFO stack of DataWidth-bit words with a registered top-of-stack.
// Push/Pop are active-low and level-sensitive. Each sampled cycle is one operation.
// Overflow and Underflow are sticky until Reset.
module register_stack #(
  parameter int DataWidth = 16,
  parameter int Depth     = 8,
  parameter int AddrWidth = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Push,
  input  logic                 Pop,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic [AddrWidth:0]   Count,
  output logic                 Empty,
  output logic                 Full,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam logic [AddrWidth:0]   CountZero  = '0;
  localparam logic [AddrWidth:0]   CountOne   = (AddrWidth+1)'(1);
  localparam logic [AddrWidth:0]   DepthCount = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth-1:0] AddrOne    = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] AddrTwo    = AddrWidth'(2);
  localparam logic [DataWidth-1:0] DataZero   = '0;

  // Storage is never read before an entry is pushed, so it carries no reset.
  logic [DataWidth-1:0] mem_r [Depth];

  logic [AddrWidth:0]   count_r;
  logic [DataWidth-1:0] dout_r;
  logic                 overflow_r;
  logic                 underflow_r;

  logic [AddrWidth:0]   count_s;
  logic [DataWidth-1:0] dout_s;
  logic                 overflow_s;
  logic                 underflow_s;
  logic                 we_s;
  logic [AddrWidth-1:0] waddr_s;
  logic                 push_req_s;
  logic                 pop_req_s;
  logic                 empty_s;
  logic                 full_s;
  logic [AddrWidth-1:0] lo_s;
  logic [AddrWidth-1:0] top_idx_s;
  logic [AddrWidth-1:0] below_idx_s;

  assign push_req_s  = ~Push;
  assign pop_req_s   = ~Pop;
  assign empty_s     = (count_r == CountZero);
  assign full_s      = (count_r == DepthCount);
  // Depth is a power of two, so modulo-Depth slot arithmetic is exact here.
  assign lo_s        = count_r[AddrWidth-1:0];
  assign top_idx_s   = lo_s - AddrOne;
  assign below_idx_s = lo_s - AddrTwo;

  // Decode the request pair into next count, top-of-stack, flags and storage write.
  always_comb begin
    count_s     = count_r;
    dout_s      = dout_r;
    overflow_s  = overflow_r;
    underflow_s = underflow_r;
    we_s        = 1'b0;
    waddr_s     = lo_s;
    case ({push_req_s, pop_req_s})
      2'b10: begin
        if (!full_s) begin
          we_s    = 1'b1;
          waddr_s = lo_s;
          count_s = count_r + CountOne;
          dout_s  = DIn;
        end else begin
          overflow_s = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          count_s = count_r - CountOne;
          if (count_r > CountOne) begin
            dout_s = mem_r[below_idx_s];
          end else begin
            dout_s = DataZero;
          end
        end else begin
          underflow_s = 1'b1;
        end
      end
      2'b11: begin
        if (!empty_s) begin
          // Replace the top in place; no flag changes even when full.
          we_s    = 1'b1;
          waddr_s = top_idx_s;
          dout_s  = DIn;
        end else begin
          // Nothing to pop, so this degrades to a plain push without Underflow.
          we_s    = 1'b1;
          waddr_s = lo_s;
          count_s = CountOne;
          dout_s  = DIn;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // Control state: count, registered top-of-stack and sticky error flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r     <= CountZero;
      dout_r      <= DataZero;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_s;
      dout_r      <= dout_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
    end
  end

  // Storage write port for pushes and top replacement.
  always_ff @(posedge Clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= DIn;
    end
  end

  assign DOut      = dout_r;
  assign Count     = count_r;
  assign Empty     = empty_s;
  assign Full      = full_s;
  assign Overflow  = overflow_r;
  assign Underflow = underflow_r;

endmodule

// File: tb/tb_register_stack.sv
// tb_register_stack: scenario tasks plus randomized traffic checked against a queue model.
module tb_register_stack;

  logic        Clk;
  logic        Reset;
  logic        Push;
  logic        Pop;
  logic [15:0] DIn;
  logic [15:0] DOut;
  logic [3:0]  Count;
  logic        Empty;
  logic        Full;
  logic        Overflow;
  logic        Underflow;

  int tests_run;
  int tests_failed;

  // Reference model: a queue of words plus the expected top and sticky flags.
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  logic        m_ovf;
  logic        m_unf;

  register_stack #(.DataWidth(16), .Depth(8), .AddrWidth(3)) dut (
    .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .DIn(DIn),
    .DOut(DOut), .Count(Count), .Empty(Empty), .Full(Full),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void model_reset();
    mq.delete();
    m_dout = 16'h0000;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  // pu/po are active-high requests here.
  function automatic void model_apply(input bit pu, input bit po, input logic [15:0] d);
    if (pu && !po) begin
      if (mq.size() < 8) begin mq.push_back(d); m_dout = d; end
      else m_ovf = 1'b1;
    end else if (!pu && po) begin
      if (mq.size() > 0) begin
        void'(mq.pop_back());
        m_dout = (mq.size() > 0) ? mq[mq.size()-1] : 16'h0000;
      end else m_unf = 1'b1;
    end else if (pu && po) begin
      if (mq.size() > 0) mq[mq.size()-1] = d;
      else mq.push_back(d);
      m_dout = d;
    end
  endfunction

  function automatic logic [23:0] exp_vec();
    return {m_dout, 4'(mq.size()), (mq.size() == 0), (mq.size() == 8), m_ovf, m_unf};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {DOut, Count, Empty, Full, Overflow, Underflow};
  endfunction

  // One clock of traffic; outputs are settled 1 time unit after the edge.
  task automatic step(input bit pu, input bit po, input logic [15:0] d);
    Push = ~pu;
    Pop  = ~po;
    DIn  = d;
    @(posedge Clk);
    #1;
    model_apply(pu, po, d);
  endtask

  task automatic idle();
    Push = 1'b1;
    Pop  = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    DIn = 16'h0000;
    #50;
    Reset = 1'b0;
    model_reset();
    #2;
    tests_run++;
    if (obs_vec() !== 24'h0000_08) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), 24'h0000_08);
    end
    #5;
    Reset = 1'b1;
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h00A0 + 16'(i));
      tests_run++;
      if (obs_vec() !== exp_vec() || DOut !== 16'h00A0 + 16'(i)) begin
        tests_failed++;
        $display("FAIL push_seq[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pop_seq[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if (DOut !== 16'h0000 || Empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL pop_to_empty: got dout=%h empty=%b want 0000/1", DOut, Empty);
    end
    idle();
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0010 + 16'(i));
    tests_run++;
    if (obs_vec() !== exp_vec() || Full !== 1'b1 || DOut !== 16'h0017) begin
      tests_failed++;
      $display("FAIL fill: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b1, 1'b0, 16'hFFFF);
    tests_run++;
    if (obs_vec() !== exp_vec() || Overflow !== 1'b1 || Count !== 4'd8 || DOut !== 16'h0017) begin
      tests_failed++;
      $display("FAIL overflow: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_underflow_simul();
    step(1'b0, 1'b1, 16'h0000);
    tests_run++;
    if (obs_vec() !== exp_vec() || Underflow !== 1'b1 || Count !== 4'd0) begin
      tests_failed++;
      $display("FAIL underflow: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b1, 1'b1, 16'h1234);
    tests_run++;
    if (obs_vec() !== exp_vec() || Count !== 4'd1 || DOut !== 16'h1234) begin
      tests_failed++;
      $display("FAIL pushpop_empty: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 16'h0000);
    idle();
  endtask

  task automatic test_replace();
    step(1'b1, 1'b0, 16'h00A0);
    step(1'b1, 1'b0, 16'h00A1);
    step(1'b1, 1'b1, 16'hBEEF);
    tests_run++;
    if (obs_vec() !== exp_vec() || Count !== 4'd2 || DOut !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL replace: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 16'h0000);
    tests_run++;
    if (obs_vec() !== exp_vec() || DOut !== 16'h00A0) begin
      tests_failed++;
      $display("FAIL replace_pop: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 16'h0000);
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0300 + 16'(i));
    step(1'b1, 1'b0, 16'h0BAD);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000);
    idle();
    tests_run++;
    if (Count !== 4'd5 || Overflow !== 1'b1 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL pre_reset: got %h want %h", obs_vec(), exp_vec());
    end
    #1;
    Reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (obs_vec() !== 24'h0000_08) begin
      tests_failed++;
      $display("FAIL async_reset: got %h want %h", obs_vec(), 24'h0000_08);
    end
    #1;
    Reset = 1'b1;
    step(1'b1, 1'b0, 16'h4242);
    tests_run++;
    if (obs_vec() !== exp_vec() || Count !== 4'd1) begin
      tests_failed++;
      $display("FAIL post_reset_push: got %h want %h", obs_vec(), exp_vec());
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      bit pu;
      bit po;
      r  = $urandom_range(0, 9);
      // Bias toward pushes early and pops later so both Full and Empty get exercised.
      pu = (n % 100 < 50) ? (r < 6) : (r < 3);
      po = (n % 100 < 50) ? (r >= 5 && r < 7) : (r >= 2 && r < 8);
      step(pu, po, 16'($urandom));
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_reset();
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_underflow_simul();
    test_replace();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
